uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 p_data  input  DATA_WIDTH  parallel word to transmit.
REQ-005 data_valid  input  1  request to transmit p_data.
REQ-006 par_en  input  1  1 = parity bit inserted after the data bits.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 scale  input  6  bit period in clk cycles; legal range 4..63.
REQ-009 tx_out  output  1  serial line; idles high.
REQ-010 busy  output  1  high while a frame is in progress.

Function
REQ-011 tx_out and busy SHALL be driven directly from flops, with no combinational path from any input.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE, data_valid=1 on an edge SHALL accept the request: latch p_data, par_en, par_typ and scale, then enter START.
REQ-014 Acceptance at edge N SHALL give tx_out=0 and busy=1 from edge N+1, so latency is 1 cycle.
REQ-015 data_valid SHALL be ignored outside IDLE; there is no queueing and the latched values are unaffected.
REQ-016 Each bit SHALL last exactly scale_latched cycles, counted by a 6-bit period counter running 0..scale_latched-1.
REQ-017 A latched scale below 4 SHALL be clamped to 4.
REQ-018 START SHALL drive tx_out=0 for one bit period, then go to DATA.
REQ-019 DATA SHALL send the latched data LSB first, one bit per period, using a bit index 0..DATA_WIDTH-1.
REQ-020 After the last data bit, DATA SHALL go to PARITY if par_en_latched=1, otherwise to STOP.
REQ-021 PARITY SHALL drive the XOR of all latched data bits when even, and its inverse when odd, for one bit period.
REQ-022 STOP SHALL drive tx_out=1 for one bit period, then go to IDLE.
REQ-023 busy SHALL fall on the edge that enters IDLE.
REQ-024 Frame length in cycles SHALL be (DATA_WIDTH+2+par_en_latched)*scale_latched.
REQ-025 A new request SHALL be accepted only in IDLE, so consecutive frames are separated by at least 1 idle cycle with tx_out=1.
REQ-026 Changes to scale, par_en, par_typ or p_data during a frame SHALL have no effect on that frame.

Reset
REQ-027 While rst=1 at an edge, the FSM SHALL enter IDLE and both counters SHALL clear.
REQ-028 While rst=1 at an edge, tx_out SHALL be 1, busy SHALL be 0 and the latched data SHALL be 0.
REQ-029 A reset mid-frame SHALL abort the frame on that edge, with no partial stop bit and no pending request retained.
REQ-030 data_valid SHALL be ignored in any cycle where rst=1.

Verification
REQ-031 scale=8, par_en=0, p_data=0xA5 pulsed 1 cycle -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; busy high exactly 80 cycles.
REQ-032 scale=16, par_en=1, p_data=0x03 -> parity bit 0 with par_typ=0 and 1 with par_typ=1; frame lasts 176 cycles.
REQ-033 Frame 0x5A started, then data_valid with 0xFF during DATA -> 0x5A frame intact; no second frame follows.
REQ-034 rst=1 during data bit 3 -> next cycle tx_out=1 and busy=0; a following 0x81 frame is bit-exact.
REQ-035 scale=2, p_data=0x00 -> bit period clamped to 4; frame lasts 40 cycles.
REQ-036 data_valid held high, scale=4, no parity -> frames of 40 cycles separated by exactly 1 idle cycle with tx_out=1.

Source files
------------

// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle for uart_tx: parallel request in, serial line and busy out.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            scale;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, scale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, scale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Every frame setting is captured on acceptance; tx_out and busy come straight from flops.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            scale_q, scale_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  period_done;
  logic [IDX_W-1:0]      idx_next;

  assign period_done = (cnt_q == scale_q - 6'd1);
  assign idx_next    = idx_q + 1'b1;

  // tx_d is the value the line will carry in the next cycle, so the flop output leads nothing combinational.
  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    scale_d   = scale_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      cnt_d = period_done ? 6'd0 : cnt_q + 6'd1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (bus.data_valid) begin
          data_d    = bus.p_data;
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
          scale_d   = (bus.scale < 6'd4) ? 6'd4 : bus.scale;
          idx_d     = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (period_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (period_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ par_typ_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_next;
            tx_d  = data_q[idx_next];
          end
        end
      end
      PARITY: begin
        if (period_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (period_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched frame settings are cleared on reset too, so nothing from an aborted frame survives.
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      scale_q   <= 6'd4;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      scale_q   <= scale_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: each frame's line waveform is compared with a
// reference built from the frame format (start, LSB-first data, parity, stop).
module tb_uart_tx;
  localparam int DW      = 8;
  localparam int TIMEOUT = 2000;

  typedef logic wave_t[$];

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: list the frame's bits, then stretch each to the effective bit period.
  function automatic wave_t expected_wave(input logic [DW-1:0] d, input logic pe,
                                          input logic pt, input int sc);
    wave_t bits, w;
    int    period;
    period = (sc < 4) ? 4 : sc;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < period; k++) w.push_back(bits[i]);
    return w;
  endfunction

  // Presents a request for one cycle (or leaves it held) and checks the one-cycle latency.
  task automatic start_frame(input string name, input logic [DW-1:0] d, input logic pe,
                             input logic pt, input logic [5:0] sc, input bit hold);
    @(negedge clk);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.scale      = sc;
    bus.data_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.data_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tx_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: busy=%b tx_out=%b, required busy=1 tx_out=0",
               name, bus.busy, bus.tx_out);
    end
  endtask

  // Records tx_out each cycle while busy; optionally scrambles the inputs mid-frame.
  task automatic capture(input string name, input bit disturb, input int exp_len,
                         output wave_t got);
    int n = 0;
    got = {};
    while (bus.busy === 1'b1 && n < TIMEOUT) begin
      got.push_back(bus.tx_out);
      if (disturb) begin
        if (n < exp_len - 3) begin
          bus.p_data     = (n < 20) ? 8'hFF : DW'($urandom);
          bus.par_en     = 1'($urandom);
          bus.par_typ    = 1'($urandom);
          bus.scale      = 6'($urandom);
          bus.data_valid = 1'b1;
        end else begin
          bus.data_valid = 1'b0;
        end
      end
      n++;
      @(negedge clk);
    end
    if (n >= TIMEOUT) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: busy still high after %0d cycles, required to fall", name, n);
    end
  endtask

  task automatic compare_frame(input string name, input logic [DW-1:0] d, input logic pe,
                               input logic pt, input int sc, input wave_t got);
    wave_t exp;
    int    bad;
    exp = expected_wave(d, pe, pt, sc);
    n_checks++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s frame_len: busy for %0d cycles, required %0d", name, got.size(), exp.size());
    end
    bad = -1;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s waveform: cycle %0d tx_out=%b, required %b", name, bad, got[bad], exp[bad]);
    end
    n_checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: tx_out=%b busy=%b, required tx_out=1 busy=0",
               name, bus.tx_out, bus.busy);
    end
  endtask

  task automatic run_frame(input string name, input logic [DW-1:0] d, input logic pe,
                           input logic pt, input logic [5:0] sc, input bit disturb);
    wave_t got, exp;
    exp = expected_wave(d, pe, pt, int'(sc));
    start_frame(name, d, pe, pt, sc, 1'b0);
    capture(name, disturb, exp.size(), got);
    compare_frame(name, d, pe, pt, int'(sc), got);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int starts = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) starts++;
      @(negedge clk);
    end
    n_checks++;
    if (starts != 0) begin
      n_fail++;
      $display("FAIL %s quiet: %0d non-idle cycles, required 0", name, starts);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h3C;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.scale      = 6'd8;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tx_out=%b busy=%b, required tx_out=1 busy=0", bus.tx_out, bus.busy);
    end
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    expect_quiet("reset_release", 10);
  endtask

  task automatic test_directed();
    run_frame("a5_s8", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
    run_frame("03_even", 8'h03, 1'b1, 1'b0, 6'd16, 1'b0);
    run_frame("03_odd", 8'h03, 1'b1, 1'b1, 6'd16, 1'b0);
    run_frame("clamp_s2", 8'h00, 1'b0, 1'b0, 6'd2, 1'b0);
    run_frame("s63_odd", 8'hE7, 1'b1, 1'b1, 6'd63, 1'b0);
  endtask

  task automatic test_ignore_valid();
    run_frame("5a_disturb", 8'h5A, 1'b1, 1'b0, 6'd6, 1'b1);
    expect_quiet("no_second_frame", 60);
  endtask

  task automatic test_reset_mid_frame();
    start_frame("rst_mid", 8'hC3, 1'b0, 1'b0, 6'd8, 1'b0);
    repeat (34) @(negedge clk);
    rst            = 1'b1;
    bus.data_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid abort: tx_out=%b busy=%b, required tx_out=1 busy=0", bus.tx_out, bus.busy);
    end
    @(negedge clk);
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    expect_quiet("rst_mid_no_pending", 20);
    run_frame("81_after_rst", 8'h81, 1'b0, 1'b0, 6'd8, 1'b0);
  endtask

  task automatic test_back_to_back();
    wave_t got;
    int    idle = 0;
    start_frame("b2b_1", 8'h96, 1'b0, 1'b0, 6'd4, 1'b1);
    capture("b2b_1", 1'b0, 40, got);
    n_checks++;
    if (got.size() != 40) begin
      n_fail++;
      $display("FAIL b2b_1 frame_len: %0d cycles, required 40", got.size());
    end
    while (bus.busy !== 1'b1 && idle < 100) begin
      if (bus.tx_out !== 1'b1) idle = 1000;
      idle++;
      @(negedge clk);
    end
    n_checks++;
    if (idle != 1) begin
      n_fail++;
      $display("FAIL b2b gap: %0d idle cycles (>1000 means tx_out low while idle), required 1", idle);
    end
    bus.data_valid = 1'b0;
    capture("b2b_2", 1'b0, 40, got);
    compare_frame("b2b_2", 8'h96, 1'b0, 1'b0, 4, got);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] d;
      logic          pe, pt;
      logic [5:0]    sc;
      d  = DW'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      sc = 6'($urandom_range(0, 20));
      run_frame($sformatf("rand%0d", i), d, pe, pt, sc, i[0]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_valid();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
